// File: rtl/regfile_dffe_pkg.sv
// Shared register-file constants and types.
// Decode and writeback use these to size rs/rt/rd and operands.
package regfile_dffe_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_DEPTH  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_dffe_if.sv
// Register-file access bundle: one write port, two read ports.
// Master drives addresses/data, slave returns read data.
interface regfile_dffe_if
  import regfile_dffe_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int ADDR_W = REG_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;

  modport master (
    output we, waddr, wdata,
    output raddr_a, raddr_b,
    input  rdata_a, rdata_b
  );

  modport slave (
    input  we, waddr, wdata,
    input  raddr_a, raddr_b,
    output rdata_a, rdata_b
  );

endinterface

// File: rtl/regfile_dffe_reg.sv
// WIDTH-bit enabled register with asynchronous clear.
// Powers up at zero so unwritten entries never read X.
module dffe_reg_n #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r = '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/regfile_dffe.sv
// Architectural register file: one sync write, two comb reads,
// optional hardwired r0, write bypass and address range guard.
module regfile_dffe
  import regfile_dffe_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int DEPTH    = REG_DEPTH,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           clr,
  regfile_dffe_if.slave bus
);

  logic [DEPTH-1:0][WIDTH-1:0] q;
  logic [WIDTH-1:0]            mux_a;
  logic [WIDTH-1:0]            mux_b;
  logic                        wvalid;
  logic                        wzero;
  logic                        wlive;

  assign wvalid = 32'(bus.waddr) < DEPTH;
  assign wzero  = ZERO_REG && (bus.waddr == '0);
  assign wlive  = bus.we && !clr && wvalid && !wzero;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (ZERO_REG && i == 0) begin : g_zero
      assign q[i] = '0;
    end else begin : g_reg
      logic en;
      assign en = bus.we && wvalid &&
                  (bus.waddr == ADDR_W'(i));
      dffe_reg_n #(.WIDTH(WIDTH)) u_reg (
        .clk (clk),
        .en  (en),
        .clr (clr),
        .d   (bus.wdata),
        .q   (q[i])
      );
    end
  end

  // Addresses past DEPTH match no entry and fall out as zero
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.raddr_a == ADDR_W'(i)) mux_a = q[i];
      if (bus.raddr_b == ADDR_W'(i)) mux_b = q[i];
    end
  end

  always_comb begin
    bus.rdata_a = mux_a;
    if (BYPASS && wlive &&
        bus.waddr == bus.raddr_a) begin
      bus.rdata_a = bus.wdata;
    end
    if (clr || (ZERO_REG && bus.raddr_a == '0)) begin
      bus.rdata_a = '0;
    end
  end

  always_comb begin
    bus.rdata_b = mux_b;
    if (BYPASS && wlive &&
        bus.waddr == bus.raddr_b) begin
      bus.rdata_b = bus.wdata;
    end
    if (clr || (ZERO_REG && bus.raddr_b == '0)) begin
      bus.rdata_b = '0;
    end
  end

endmodule

// File: tb/tb_regfile_dffe.sv
// Bench for regfile_dffe: three configurations driven in lockstep
// against an array-based reference model.
module tb_regfile_dffe;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;

  int checks = 0;
  int errors = 0;

  localparam int NCFG = 3;
  int depth_c [NCFG] = '{32, 32, 20};
  bit byp_c   [NCFG] = '{1'b1, 1'b0, 1'b1};
  bit zr_c    [NCFG] = '{1'b1, 1'b0, 1'b1};

  logic [31:0] mem [NCFG][32];
  logic [31:0] ra [NCFG];
  logic [31:0] rb [NCFG];

  always #5 clk = ~clk;

  regfile_dffe_if #(.WIDTH(32), .ADDR_W(5)) if0 ();
  regfile_dffe_if #(.WIDTH(32), .ADDR_W(5)) if1 ();
  regfile_dffe_if #(.WIDTH(32), .ADDR_W(5)) if2 ();

  assign if0.we = we;  assign if0.waddr = waddr;
  assign if0.wdata = wdata;
  assign if0.raddr_a = raddr_a;
  assign if0.raddr_b = raddr_b;
  assign if1.we = we;  assign if1.waddr = waddr;
  assign if1.wdata = wdata;
  assign if1.raddr_a = raddr_a;
  assign if1.raddr_b = raddr_b;
  assign if2.we = we;  assign if2.waddr = waddr;
  assign if2.wdata = wdata;
  assign if2.raddr_a = raddr_a;
  assign if2.raddr_b = raddr_b;

  assign ra[0] = if0.rdata_a;  assign rb[0] = if0.rdata_b;
  assign ra[1] = if1.rdata_a;  assign rb[1] = if1.rdata_b;
  assign ra[2] = if2.rdata_a;  assign rb[2] = if2.rdata_b;

  regfile_dffe #(
    .WIDTH(32), .DEPTH(32), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut0 (.clk(clk), .clr(clr), .bus(if0.slave));

  regfile_dffe #(
    .WIDTH(32), .DEPTH(32), .BYPASS(1'b0), .ZERO_REG(1'b0)
  ) dut1 (.clk(clk), .clr(clr), .bus(if1.slave));

  regfile_dffe #(
    .WIDTH(32), .DEPTH(20), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut2 (.clk(clk), .clr(clr), .bus(if2.slave));

  function automatic bit writable(int k, int a);
    return a < depth_c[k] && !(zr_c[k] && a == 0);
  endfunction

  function automatic logic [31:0] model_rd(int k, int a);
    if (clr) return 32'h0;
    if (a >= depth_c[k]) return 32'h0;
    if (zr_c[k] && a == 0) return 32'h0;
    if (byp_c[k] && we && int'(waddr) == a &&
        writable(k, a)) return wdata;
    return mem[k][a];
  endfunction

  task automatic cmp(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    #1;
    for (int k = 0; k < NCFG; k++) begin
      cmp($sformatf("%s c%0d a%0d", tag, k, raddr_a),
          ra[k], model_rd(k, int'(raddr_a)));
      cmp($sformatf("%s c%0d b%0d", tag, k, raddr_b),
          rb[k], model_rd(k, int'(raddr_b)));
    end
  endtask

  task automatic tick();
    for (int k = 0; k < NCFG; k++) begin
      if (!clr && we && writable(k, int'(waddr)))
        mem[k][int'(waddr)] = wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_clr(logic v);
    clr = v;
    if (v) begin
      for (int k = 0; k < NCFG; k++)
        for (int a = 0; a < 32; a++) mem[k][a] = '0;
    end
  endtask

  task automatic scan(string tag);
    we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr_a = 5'(a);
      raddr_b = 5'(31 - a);
      check_all(tag);
    end
  endtask

  initial begin
    for (int k = 0; k < NCFG; k++)
      for (int a = 0; a < 32; a++) mem[k][a] = '0;

    #1;
    raddr_a = 5'd5; raddr_b = 5'd0;
    check_all("init");

    we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 0;
    check_all("r5 wr");
    cmp("r5 val", ra[0], 32'hDEADBEEF);
    #2;
    set_clr(1'b1);
    check_all("clr async");
    cmp("clr r5", ra[0], 32'h0);
    tick();
    set_clr(1'b0);

    we = 1; waddr = 5'd3; wdata = 32'h12345678;
    raddr_a = 5'd3; raddr_b = 5'd4;
    check_all("wr3 pre");
    tick();
    we = 0;
    check_all("wr3 post");
    cmp("r3 val", ra[1], 32'h12345678);
    cmp("r4 val", rb[0], 32'h0);

    we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    raddr_a = 5'd0; raddr_b = 5'd0;
    check_all("zero pre");
    tick();
    we = 0;
    check_all("zero post");
    cmp("r0 zr", ra[0], 32'h0);

    we = 1; waddr = 5'd7; wdata = 32'h11;
    tick();
    wdata = 32'h22;
    raddr_a = 5'd7; raddr_b = 5'd7;
    check_all("byp pre");
    cmp("byp1 a", ra[0], 32'h22);
    cmp("byp0 b", rb[1], 32'h11);
    tick();
    we = 0;
    check_all("byp post");
    cmp("byp0 post", ra[1], 32'h22);

    we = 1; waddr = 5'd25; wdata = 32'hAA;
    raddr_a = 5'd25; raddr_b = 5'd19;
    check_all("range pre");
    tick();
    we = 0;
    check_all("range post");
    cmp("range d20", ra[2], 32'h0);
    scan("range scan");

    set_clr(1'b1);
    we = 1; waddr = 5'd9; wdata = 32'h55;
    raddr_a = 5'd9; raddr_b = 5'd9;
    tick();
    check_all("clr wr");
    set_clr(1'b0);
    we = 0;
    check_all("clr wr post");
    cmp("r9 clr", ra[1], 32'h0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_clr(1'b1);
        check_all("rnd clr");
      end
      we      = 1'($urandom_range(0, 3) != 0);
      waddr   = 5'($urandom_range(0, 31));
      wdata   = $urandom;
      raddr_a = ($urandom_range(0, 2) == 0) ?
                waddr : 5'($urandom_range(0, 31));
      raddr_b = ($urandom_range(0, 3) == 0) ?
                raddr_a : 5'($urandom_range(0, 31));
      check_all("rnd pre");
      tick();
      if (clr) set_clr(1'b0);
    end
    scan("final scan");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
